// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for stream_mux_arb: N producer channels in, one registered stream out.
// The slave modport is the arbiter's view; master is the producers/consumer side.
interface stream_mux_arb_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   ch_en;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_ready;

  modport master (
    output in_valid, in_data, ch_en, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  in_valid, in_data, ch_en, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/stream_mux_arb.sv
// N-to-1 stream arbiter (fixed-priority or round-robin) with a single registered
// output stage that can drain and refill in the same cycle.
module stream_mux_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 1
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_arb_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt_oh;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          found;
  logic          load;
  logic          xfer;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req      = bus.in_valid & bus.ch_en;
    load     = ~out_valid_q | bus.out_ready;
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    gnt_oh   = '0;

    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          found     = 1'b1;
          gnt_idx   = SW'(i);
          gnt_data  = bus.in_data[i*W +: W];
          gnt_oh[i] = 1'b1;
        end
      end
    end else begin
      // Round-robin as two passes: channels above the pointer first, then wrap to 0..ptr.
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i > int'(ptr_q))) begin
          found     = 1'b1;
          gnt_idx   = SW'(i);
          gnt_data  = bus.in_data[i*W +: W];
          gnt_oh[i] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i <= int'(ptr_q))) begin
          found     = 1'b1;
          gnt_idx   = SW'(i);
          gnt_data  = bus.in_data[i*W +: W];
          gnt_oh[i] = 1'b1;
        end
      end
    end

    xfer        = load & found;
    out_valid_d = load ? found : out_valid_q;
    out_data_d  = xfer ? gnt_data : out_data_q;
    out_chan_d  = xfer ? gnt_idx : out_chan_q;
    ptr_d       = ((MODE != 0) && xfer) ? gnt_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = load ? gnt_oh : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Drives a fixed-priority and a round-robin instance side by side and compares both
// against a cycle-level reference model of the arbitration and output register.
module tb_stream_mux_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.N(N), .W(W)) bus0 ();
  stream_mux_arb_if #(.N(N), .W(W)) bus1 ();

  stream_mux_arb #(.N(N), .W(W), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  stream_mux_arb #(.N(N), .W(W), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Per-instance producer state (index 0 = fixed priority, 1 = round robin)
  logic [N-1:0]   vld [2];
  logic [N*W-1:0] dat [2];
  logic [N-1:0]   en;
  logic           rdy;
  bit             auto_prod;

  assign bus0.in_valid  = vld[0];
  assign bus0.in_data   = dat[0];
  assign bus0.ch_en     = en;
  assign bus0.out_ready = rdy;
  assign bus1.in_valid  = vld[1];
  assign bus1.in_data   = dat[1];
  assign bus1.ch_en     = en;
  assign bus1.out_ready = rdy;

  logic [N-1:0]  ir [2];
  logic          ov [2];
  logic [W-1:0]  od [2];
  logic [SW-1:0] oc [2];

  always_comb begin
    ir[0] = bus0.in_ready;  ov[0] = bus0.out_valid;
    od[0] = bus0.out_data;  oc[0] = bus0.out_chan;
    ir[1] = bus1.in_ready;  ov[1] = bus1.out_valid;
    od[1] = bus1.out_data;  oc[1] = bus1.out_chan;
  end

  // Reference model: contents of the output register and the last granted channel
  bit           mv [2];
  logic [W-1:0] md [2];
  int           mc [2];
  int           mp [2];
  int           cnt [2][N];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Winner = requester with smallest distance from the priority origin
  // (channel 0 for fixed priority, the channel after the last grant for round robin).
  function automatic int pick(input int m, input logic [N-1:0] r);
    int best = -1;
    int bd   = N + 1;
    int d;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (m == 0) ? i : (i - mp[m] - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0;
      md[m] = '0;
      mc[m] = 0;
      mp[m] = N - 1;
    end
  endtask

  task automatic clear_cnt();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) cnt[m][i] = 0;
  endtask

  task automatic set_all(input logic [N-1:0] v);
    for (int m = 0; m < 2; m++) vld[m] = v;
  endtask

  task automatic set_chan(input int i, input logic [W-1:0] d);
    for (int m = 0; m < 2; m++) dat[m][i*W +: W] = d;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic step();
    int   g [2];
    logic load;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      load = !mv[m] || rdy;
      g[m] = load ? pick(m, vld[m] & en) : -1;
      check($sformatf("m%0d_in_ready", m), 32'(ir[m]), (g[m] >= 0) ? (32'd1 << g[m]) : 32'd0);
      check($sformatf("m%0d_out_valid", m), 32'(ov[m]), 32'(mv[m]));
      check($sformatf("m%0d_out_data", m), 32'(od[m]), 32'(md[m]));
      check($sformatf("m%0d_out_chan", m), 32'(oc[m]), 32'(mc[m]));
      for (int i = 0; i < N; i++) if (ir[m][i]) cnt[m][i]++;
      if (load) begin
        if (g[m] >= 0) begin
          mv[m] = 1'b1;
          md[m] = dat[m][g[m]*W +: W];
          mc[m] = g[m];
          mp[m] = g[m];
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (auto_prod) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          if (g[m] == i) vld[m][i] = 1'b0;
          if (!vld[m][i] && ($urandom_range(0, 99) < 60)) begin
            vld[m][i]         = 1'b1;
            dat[m][i*W +: W]  = W'($urandom);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    auto_prod = 1'b0;
    en        = '1;
    rdy       = 1'b0;
    for (int m = 0; m < 2; m++) begin
      vld[m] = '0;
      dat[m] = '0;
    end
    model_reset();
    clear_cnt();

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_rst_valid", m), 32'(ov[m]), 32'd0);
      check($sformatf("m%0d_rst_data", m), 32'(od[m]), 32'd0);
      check($sformatf("m%0d_rst_chan", m), 32'(oc[m]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All channels valid, consumer always ready
    rdy = 1'b1;
    for (int i = 0; i < N; i++) set_chan(i, W'(8'h10 * (i + 1) + i));
    set_all('1);
    clear_cnt();
    step();
    check("rr_first_grant_ch0", 32'(oc[1]), 32'd0);
    repeat (7) step();
    for (int i = 0; i < N; i++)
      check($sformatf("rr_share_ch%0d", i), 32'(cnt[1][i]), 32'd2);
    check("fp_all_to_ch0", 32'(cnt[0][0]), 32'd8);

    // ch0 and ch2 competing under fixed priority
    set_all(4'b0101);
    clear_cnt();
    repeat (6) step();
    check("fp_ch2_starved", 32'(cnt[0][2]), 32'd0);
    check("fp_ch0_every_cycle", 32'(cnt[0][0]), 32'd6);

    // Channel enable masks channels 0 and 2
    en = 4'b1010;
    set_all('1);
    clear_cnt();
    repeat (8) step();
    check("en_rr_masked", 32'(cnt[1][0] + cnt[1][2]), 32'd0);
    check("en_rr_ch1", 32'(cnt[1][1]), 32'd4);
    check("en_rr_ch3", 32'(cnt[1][3]), 32'd4);
    check("en_fp_masked", 32'(cnt[0][0] + cnt[0][2]), 32'd0);

    // Backpressure: hold 0xA5 from ch1 while ch3 waits with 0x3C
    en = '1;
    set_all('0);
    repeat (2) step();
    set_chan(1, 8'hA5);
    set_all(4'b0010);
    step();
    set_chan(3, 8'h3C);
    set_all(4'b1000);
    rdy = 1'b0;
    repeat (3) begin
      step();
      for (int m = 0; m < 2; m++) begin
        check($sformatf("m%0d_stall_data", m), 32'(od[m]), 32'hA5);
        check($sformatf("m%0d_stall_ready", m), 32'(ir[m]), 32'd0);
      end
    end
    rdy = 1'b1;
    #1;
    for (int m = 0; m < 2; m++)
      check($sformatf("m%0d_release_ready", m), 32'(ir[m]), 32'b1000);
    step();
    set_all('0);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_refill_data", m), 32'(od[m]), 32'h3C);
      check($sformatf("m%0d_refill_chan", m), 32'(oc[m]), 32'd3);
    end

    // Single word drains and the register goes empty
    repeat (2) step();
    set_chan(2, 8'h11);
    set_all(4'b0100);
    step();
    set_all('0);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_drain_v1", m), 32'(ov[m]), 32'd1);
      check($sformatf("m%0d_drain_d1", m), 32'(od[m]), 32'h11);
    end
    step();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_drain_v0", m), 32'(ov[m]), 32'd0);
      check($sformatf("m%0d_drain_hold", m), 32'(od[m]), 32'h11);
    end
    step();

    // Asynchronous reset in the middle of a stream
    set_all('1);
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_async_valid", m), 32'(ov[m]), 32'd0);
      check($sformatf("m%0d_async_data", m), 32'(od[m]), 32'd0);
      check($sformatf("m%0d_async_chan", m), 32'(oc[m]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rr_after_reset_ch0", 32'(oc[1]), 32'd0);
    check("rr_after_reset_valid", 32'(ov[1]), 32'd1);

    // Randomized traffic, enables and backpressure
    auto_prod = 1'b1;
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
